uart_receiver: RTL and testbench

//  UART RX datapath; the downstream peer of the transmitter, consuming its serial line.

---
 rtl/uart_receiver.sv | 182 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : UART RX datapath. Oversamples rx on s_tick, qualifies the
//                start bit at mid-bit, shifts data LSB-first, checks the stop
//                bit(s) and presents each byte with valid/overrun/frame flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
   parameter int DBIT      = 8,   // data bits per frame (5..8)
   parameter int SB_TICK   = 16,  // s_ticks per bit period (even, >= 8)
   parameter int STOP_BITS = 1    // stop bits checked (1 or 2)
) (
   input  logic            clk,
   input  logic            arst_n,
   input  logic            rst,
   input  logic            rx_en,
   input  logic            rx,
   input  logic            s_tick,
   input  logic            rx_rd,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            rx_valid,
   output logic            rx_busy,
   output logic            frame_err,
   output logic            overrun
);

   localparam int SW = $clog2(STOP_BITS * SB_TICK);
   localparam int NW = $clog2(DBIT);

   localparam logic [SW-1:0] HALF_LAST = SW'(SB_TICK / 2 - 1);
   localparam logic [SW-1:0] BIT_LAST  = SW'(SB_TICK - 1);
   localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS * SB_TICK - 1);
   localparam logic [NW-1:0] DATA_LAST = NW'(DBIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state;
   logic            rx_meta;
   logic            rx_s;
   logic [SW-1:0]   s_cnt;
   logic [NW-1:0]   n_cnt;
   logic [DBIT-1:0] shreg;
   logic            ferr_int;
   logic            stop_sample;
   logic            complete;

   // Stop bits are sampled at the end of each SB_TICK window inside STOP;
   // the frame completes on the last of those samples.
   always_comb begin
      stop_sample = (s_cnt == BIT_LAST) || (s_cnt == STOP_LAST);
      complete    = (state == STOP) && s_tick && (s_cnt == STOP_LAST);
      rx_busy     = (state != IDLE);
   end

   // Two-flop synchroniser; resets to the idle-high line level.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Frame FSM: start qualification, data shifting and stop-bit checking.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state    <= IDLE;
         s_cnt    <= '0;
         n_cnt    <= '0;
         shreg    <= '0;
         ferr_int <= 1'b0;
      end else if (rst) begin
         state    <= IDLE;
         s_cnt    <= '0;
         n_cnt    <= '0;
         shreg    <= '0;
         ferr_int <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Edge detect runs every clk so the start count begins promptly.
               if (rx_en && !rx_s) begin
                  state <= START;
                  s_cnt <= '0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_cnt == HALF_LAST) begin
                     if (!rx_s) begin
                        state    <= DATA;
                        s_cnt    <= '0;
                        n_cnt    <= '0;
                        ferr_int <= 1'b0;
                     end else begin
                        // Line went high again before mid-bit: a glitch.
                        state <= IDLE;
                     end
                  end else begin
                     s_cnt <= s_cnt + SW'(1);
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_cnt == BIT_LAST) begin
                     shreg <= {rx_s, shreg[DBIT-1:1]};
                     s_cnt <= '0;
                     if (n_cnt == DATA_LAST) begin
                        state <= STOP;
                     end else begin
                        n_cnt <= n_cnt + NW'(1);
                     end
                  end else begin
                     s_cnt <= s_cnt + SW'(1);
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (stop_sample && !rx_s) begin
                     ferr_int <= 1'b1;
                  end
                  if (s_cnt == STOP_LAST) begin
                     state <= IDLE;
                     s_cnt <= '0;
                  end else begin
                     s_cnt <= s_cnt + SW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Delivery to the register side: byte, flags and the valid/overrun handshake.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         dout         <= '0;
         rx_done_tick <= 1'b0;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;
      end else if (rst) begin
         dout         <= '0;
         rx_done_tick <= 1'b0;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         rx_done_tick <= complete;
         if (complete) begin
            dout      <= shreg;
            // Include the final stop sample taken on this very tick.
            frame_err <= ferr_int | ~rx_s;
            rx_valid  <= 1'b1;
            // A read in the same clk consumes the old byte, so no overrun.
            if (rx_valid && !rx_rd) begin
               overrun <= 1'b1;
            end
         end else if (rx_rd && rx_valid) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Self-checking bench for uart_receiver (1 and 2 stop bits).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

   localparam int SB = 16;

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       rst = 1'b0;
   logic       rx_en = 1'b1;
   logic       rx = 1'b1;
   logic       rx2 = 1'b1;
   logic       s_tick = 1'b0;
   logic       rx_rd = 1'b0;
   logic       rx_rd2 = 1'b0;
   logic [7:0] dout, dout2;
   logic       done, done2, valid, valid2, busy, busy2, ferr, ferr2, ovr, ovr2;

   int n_cmp = 0;
   int n_err = 0;
   int div = 0;
   int done_cnt = 0;
   int done_cnt2 = 0;

   // Reference model of the register-side view of the single-stop receiver.
   logic [7:0] m_dout = 8'h00;
   logic       m_valid = 1'b0;
   logic       m_ovr = 1'b0;
   logic       m_ferr = 1'b0;
   int         m_done = 0;

   uart_receiver #(.DBIT(8), .SB_TICK(SB), .STOP_BITS(1)) dut (
      .clk(clk), .arst_n(arst_n), .rst(rst), .rx_en(rx_en), .rx(rx),
      .s_tick(s_tick), .rx_rd(rx_rd), .dout(dout), .rx_done_tick(done),
      .rx_valid(valid), .rx_busy(busy), .frame_err(ferr), .overrun(ovr)
   );

   uart_receiver #(.DBIT(8), .SB_TICK(SB), .STOP_BITS(2)) dut2 (
      .clk(clk), .arst_n(arst_n), .rst(rst), .rx_en(1'b1), .rx(rx2),
      .s_tick(s_tick), .rx_rd(rx_rd2), .dout(dout2), .rx_done_tick(done2),
      .rx_valid(valid2), .rx_busy(busy2), .frame_err(ferr2), .overrun(ovr2)
   );

   always #5 clk = ~clk;

   // Oversample strobe: one clk high every 4 clks, changing on the falling edge.
   always @(negedge clk) begin
      if (div == 3) begin
         div    <= 0;
         s_tick <= 1'b1;
      end else begin
         div    <= div + 1;
         s_tick <= 1'b0;
      end
   end

   // Count completion pulses of both receivers.
   always @(posedge clk) begin
      if (done)  done_cnt  <= done_cnt + 1;
      if (done2) done_cnt2 <= done_cnt2 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; ) begin
         @(posedge clk);
         if (s_tick) i++;
      end
   endtask

   task automatic set_line(input int line, input logic v);
      #1;
      if (line == 1) rx = v;
      else           rx2 = v;
   endtask

   // Serial frame: start, 8 data bits LSB-first, nstop stop bits, idle gap.
   // A bad stop bit is held low just past its mid-bit sample, then released,
   // so the line is high again before any spurious start is qualified.
   task automatic send_frame(input int line, input logic [7:0] data,
                             input logic [1:0] stops, input int nstop, input int gap);
      set_line(line, 1'b0);
      wait_ticks(SB);
      for (int b = 0; b < 8; b++) begin
         set_line(line, data[b]);
         wait_ticks(SB);
      end
      for (int s = 0; s < nstop; s++) begin
         if (stops[s]) begin
            set_line(line, 1'b1);
            wait_ticks(SB);
         end else begin
            set_line(line, 1'b0);
            wait_ticks(SB / 2 + 2);
            set_line(line, 1'b1);
            wait_ticks(SB / 2 - 2);
         end
      end
      set_line(line, 1'b1);
      wait_ticks(gap);
   endtask

   task automatic pulse_rd();
      @(negedge clk);
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
      if (m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
   endtask

   task automatic model_deliver(input logic [7:0] data, input logic bad_stop);
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_dout  = data;
      m_ferr  = bad_stop;
      m_done++;
   endtask

   task automatic model_reset();
      m_dout  = 8'h00;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_ferr  = 1'b0;
   endtask

   task automatic check_all(input string tag);
      @(negedge clk);
      chk({tag, ".done_cnt"}, done_cnt, m_done);
      chk({tag, ".dout"}, {24'h0, dout}, {24'h0, m_dout});
      chk({tag, ".frame_err"}, {31'h0, ferr}, {31'h0, m_ferr});
      chk({tag, ".rx_valid"}, {31'h0, valid}, {31'h0, m_valid});
      chk({tag, ".overrun"}, {31'h0, ovr}, {31'h0, m_ovr});
   endtask

   initial begin
      logic [7:0] d;
      logic       bad;
      int         gap;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst.busy", {31'h0, busy}, 32'h0);
      chk("rst.done", {31'h0, done}, 32'h0);
      check_all("rst");
      arst_n = 1'b1;
      wait_ticks(4);

      // Single clean byte.
      send_frame(1, 8'h55, 2'b11, 1, 16);
      model_deliver(8'h55, 1'b0);
      check_all("t1");
      pulse_rd();
      check_all("t1.rd");

      // Back-to-back frames with a read after each.
      send_frame(1, 8'hF1, 2'b11, 1, 0);
      model_deliver(8'hF1, 1'b0);
      check_all("t2a");
      pulse_rd();
      send_frame(1, 8'hA3, 2'b11, 1, 4);
      model_deliver(8'hA3, 1'b0);
      check_all("t2b");
      pulse_rd();

      // Start-bit glitch: low for 4 ticks only.
      set_line(1, 1'b0);
      wait_ticks(4);
      set_line(1, 1'b1);
      @(negedge clk);
      chk("t3.busy_hi", {31'h0, busy}, 32'h1);
      wait_ticks(12);
      @(negedge clk);
      chk("t3.busy_lo", {31'h0, busy}, 32'h0);
      check_all("t3");

      // Framing error, then a clean repeat of the same byte.
      send_frame(1, 8'h3C, 2'b00, 1, 16);
      model_deliver(8'h3C, 1'b1);
      check_all("t4a");
      pulse_rd();
      send_frame(1, 8'h3C, 2'b11, 1, 16);
      model_deliver(8'h3C, 1'b0);
      check_all("t4b");
      pulse_rd();

      // Overrun from two unread bytes, cleared by one read.
      send_frame(1, 8'h12, 2'b11, 1, 8);
      model_deliver(8'h12, 1'b0);
      send_frame(1, 8'h34, 2'b11, 1, 8);
      model_deliver(8'h34, 1'b0);
      check_all("t5");
      pulse_rd();
      check_all("t5.rd");

      // Receiver disabled: frame is ignored.
      rx_en = 1'b0;
      send_frame(1, 8'h99, 2'b11, 1, 16);
      check_all("en0");
      rx_en = 1'b1;

      // Randomized bytes, stop errors and read decisions against the model.
      for (int i = 0; i < 10; i++) begin
         d   = 8'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         gap = bad ? 16 : 4 * $urandom_range(0, 4);
         send_frame(1, d, {1'b1, ~bad}, 1, gap);
         model_deliver(d, bad);
         check_all($sformatf("rnd%0d", i));
         if ($urandom_range(0, 1) == 1) begin
            pulse_rd();
            check_all($sformatf("rnd%0d.rd", i));
         end
      end

      // Asynchronous reset in data bit 3 aborts the frame and clears outputs.
      send_frame(1, 8'h77, 2'b11, 1, 16);
      model_deliver(8'h77, 1'b0);
      check_all("t6.pre");
      set_line(1, 1'b0);
      wait_ticks(SB);
      for (int b = 0; b < 3; b++) begin
         set_line(1, b[0]);
         wait_ticks(SB);
      end
      set_line(1, 1'b1);
      wait_ticks(SB / 2);
      @(negedge clk);
      arst_n = 1'b0;
      rx = 1'b1;
      #1;
      chk("t6.busy", {31'h0, busy}, 32'h0);
      model_reset();
      check_all("t6.rst");
      arst_n = 1'b1;
      wait_ticks(SB * 8);
      check_all("t6.quiet");
      send_frame(1, 8'h81, 2'b11, 1, 16);
      model_deliver(8'h81, 1'b0);
      check_all("t6.after");

      // Synchronous clear behaves like reset.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_all("srst");

      // Two stop bits: second stop low flags a framing error; then clean.
      send_frame(2, 8'h81, 2'b01, 2, 16);
      @(negedge clk);
      chk("sb2.done", done_cnt2, 32'd1);
      chk("sb2.dout", {24'h0, dout2}, 32'h81);
      chk("sb2.ferr", {31'h0, ferr2}, 32'h1);
      chk("sb2.valid", {31'h0, valid2}, 32'h1);
      send_frame(2, 8'h5A, 2'b11, 2, 16);
      @(negedge clk);
      chk("sb2b.done", done_cnt2, 32'd2);
      chk("sb2b.dout", {24'h0, dout2}, 32'h5A);
      chk("sb2b.ferr", {31'h0, ferr2}, 32'h0);
      chk("sb2b.ovr", {31'h0, ovr2}, 32'h1);
      chk("sb2.busy", {31'h0, busy2}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
